// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit peripheral: register offsets,
// STATUS bit positions and the transmitter state encoding.
package uart_pkg;

    // Word offsets as decoded from address bits [3:2]
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;

    localparam int STAT_FULL     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_OVERFLOW = 3;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic logic [31:0] pack_status(
        input logic full,
        input logic empty,
        input logic busy,
        input logic overflow
    );
        logic [31:0] s;
        s                = '0;
        s[STAT_FULL]     = full;
        s[STAT_EMPTY]    = empty;
        s[STAT_BUSY]     = busy;
        s[STAT_OVERFLOW] = overflow;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered read port;
// rd_data is updated only on an accepted pop and holds until the next one.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_reg;
    logic [ADDR_W:0]   rd_ptr_reg;
    logic [WIDTH-1:0]  rd_data_reg;
    logic              do_push;
    logic              do_pop;

    // Extra MSB distinguishes full from empty when the index bits match
    assign full    = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                     (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = rd_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
        end
        if (do_pop) begin
            rd_data_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: TXDATA writes queue bytes into a FIFO,
// the serialiser sends 8N1 frames, STATUS reports queue and line state.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        w_avalid,
    output logic        w_aready,
    input  logic [31:0] w_addr,
    input  logic [31:0] w_data,
    output logic        w_bvalid,
    input  logic        w_bready,
    input  logic        r_avalid,
    output logic        r_aready,
    input  logic [31:0] r_addr,
    output logic        r_dvalid,
    output logic [31:0] r_data,
    input  logic        r_dready,
    output logic        txd
);

    localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    logic                  w_bvalid_reg;
    logic                  r_dvalid_reg;
    logic [31:0]           r_data_reg;
    logic                  overflow_reg;

    tx_state_t             state_reg;
    logic [BAUD_W-1:0]     baud_cnt_reg;
    logic [2:0]            bit_cnt_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  txd_reg;

    logic                  w_fire;
    logic                  r_fire;
    logic                  wr_txdata;
    logic                  rd_status;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_BITS-1:0]  fifo_rd_data;
    logic                  busy;
    logic                  baud_done;
    logic [31:0]           status_word;
    logic                  unused_bits;

    assign w_aready = !w_bvalid_reg;
    assign w_bvalid = w_bvalid_reg;
    assign r_aready = !r_dvalid_reg;
    assign r_dvalid = r_dvalid_reg;
    assign r_data   = r_data_reg;
    assign txd      = txd_reg;

    assign w_fire    = w_avalid && w_aready;
    assign r_fire    = r_avalid && r_aready;
    assign wr_txdata = w_fire && (w_addr[3:2] == OFF_TXDATA);
    assign rd_status = r_fire && (r_addr[3:2] == OFF_STATUS);

    // Full is the pre-pop value, so a write racing a pop on a full FIFO is dropped
    assign fifo_push = wr_txdata && !fifo_full;
    assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;

    assign busy        = (state_reg != IDLE);
    assign baud_done   = (baud_cnt_reg == BAUD_LAST);
    assign status_word = pack_status(fifo_full, fifo_empty, busy, overflow_reg);

    assign unused_bits = ^{w_addr[31:4], w_addr[1:0], w_data[31:8],
                           r_addr[31:4], r_addr[1:0]};

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (w_data[DATA_BITS-1:0]),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_bvalid_reg <= 1'b0;
        end else if (w_fire) begin
            w_bvalid_reg <= 1'b1;
        end else if (w_bready) begin
            w_bvalid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvalid_reg <= 1'b0;
            r_data_reg   <= '0;
        end else if (r_fire) begin
            r_dvalid_reg <= 1'b1;
            r_data_reg   <= (r_addr[3:2] == OFF_STATUS) ? status_word : '0;
        end else if (r_dready) begin
            r_dvalid_reg <= 1'b0;
        end
    end

    // A dropped write in the same cycle as a STATUS read leaves overflow set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (wr_txdata && fifo_full) begin
            overflow_reg <= 1'b1;
        end else if (rd_status) begin
            overflow_reg <= 1'b0;
        end
    end

    // Popped byte lands in fifo_rd_data during START and is latched on DATA entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    baud_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    txd_reg      <= 1'b1;
                    if (!fifo_empty) begin
                        state_reg <= START;
                        txd_reg   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= DATA;
                        shift_reg    <= fifo_rd_data;
                        txd_reg      <= fifo_rd_data[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_reg <= STOP;
                            txd_reg   <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            shift_reg   <= shift_reg >> 1;
                            txd_reg     <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    txd_reg   <= 1'b1;
                end
            endcase
        end
    end

endmodule
